// File: rtl/serializer_pkg.sv
// Shared types and helpers for the w_serializer slice.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    // Width of a counter that has to hold values 0 .. width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter that saturates at zero and flags it.
module ser_bit_counter #(
    parameter int unsigned CW = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - CW'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/w_serializer.sv
// Parallel-to-serial front end feeding the sequence detector one bit per Clock on w.
// Optional even-parity trailer cycle enabled by defining W_SERIALIZER_PARITY_EN.
module w_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             w,
    output logic             w_valid,
    output logic             last
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             cnt_zero;
    logic             accept;
    logic             head;

    assign accept = din_valid && din_ready;
    assign head   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    ser_bit_counter #(.CW(CW)) u_cnt (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (accept),
        .load_val (LAST_IDX),
        .dec      (state == SHIFT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:   state_nxt = accept ? SHIFT : IDLE;
`ifdef W_SERIALIZER_PARITY_EN
            SHIFT:  state_nxt = cnt_zero ? PARITY : SHIFT;
            PARITY: state_nxt = accept ? SHIFT : IDLE;
`else
            SHIFT:  state_nxt = (!cnt_zero || accept) ? SHIFT : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // The final shift of a word empties shreg, so it rests at zero between words.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            shreg <= '0;
        else if (accept)
            shreg <= din;
        else if (state == SHIFT)
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end

`ifdef W_SERIALIZER_PARITY_EN
    logic par;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            par <= 1'b0;
        else if (accept)
            par <= ^din;
    end
`endif

    always_comb begin
        din_ready = 1'b0;
        w         = 1'b0;
        w_valid   = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: din_ready = 1'b1;
            SHIFT: begin
                w       = head;
                w_valid = 1'b1;
`ifndef W_SERIALIZER_PARITY_EN
                last      = cnt_zero;
                din_ready = cnt_zero;
`endif
            end
`ifdef W_SERIALIZER_PARITY_EN
            PARITY: begin
                w         = par;
                w_valid   = 1'b1;
                last      = 1'b1;
                din_ready = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_w_serializer.sv
// Self-checking bench for w_serializer: MSB-first and LSB-first instances driven in parallel.
module tb_w_serializer;

    localparam int unsigned W = 8;
`ifdef W_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         rdy_m, w_m, wv_m, last_m;
    logic         rdy_l, w_l, wv_l, last_l;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    w_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .Clock(Clock), .Reset(Reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .w(w_m), .w_valid(wv_m), .last(last_m)
    );

    w_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .Clock(Clock), .Reset(Reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .w(w_l), .w_valid(wv_l), .last(last_l)
    );

    // Expected frame stream: one {bit, word_end} entry per cycle a word occupies on w.
    function automatic void build(input logic [W-1:0] words[$], input bit msb, output logic [1:0] q[$]);
        logic [W-1:0] wd;
        q = {};
        foreach (words[k]) begin
            wd = words[k];
            for (int unsigned i = 0; i < W; i++)
                q.push_back({msb ? wd[W-1-i] : wd[i], (i == W-1) && !PAR});
            if (PAR)
                q.push_back({^wd, 1'b1});
        end
    endfunction

    // Producer holds each word until accepted; expected outputs are {din_ready, w, w_valid, last}.
    task automatic run_stream(input string name, input logic [W-1:0] words[$]);
        logic [1:0] qm[$], ql[$];
        logic [3:0] em, el;
        int         total, pos, widx;
        bit         acc;
        build(words, 1'b1, qm);
        build(words, 1'b0, ql);
        total = qm.size();
        pos   = -1;
        widx  = 0;
        for (int cyc = 0; cyc < total + 3; cyc++) begin
            @(negedge Clock);
            if (pos >= 0 && pos < total) begin
                em = {qm[pos][0], qm[pos][1], 1'b1, qm[pos][0]};
                el = {ql[pos][0], ql[pos][1], 1'b1, ql[pos][0]};
            end else begin
                em = 4'b1000;
                el = 4'b1000;
            end
            checks++;
            if ({rdy_m, w_m, wv_m, last_m} !== em) begin
                errors++;
                $display("FAIL %s msb cyc=%0d {rdy,w,wv,last} got=%b exp=%b", name, cyc, {rdy_m, w_m, wv_m, last_m}, em);
            end
            checks++;
            if ({rdy_l, w_l, wv_l, last_l} !== el) begin
                errors++;
                $display("FAIL %s lsb cyc=%0d {rdy,w,wv,last} got=%b exp=%b", name, cyc, {rdy_l, w_l, wv_l, last_l}, el);
            end
            din_valid = (widx < words.size());
            din       = din_valid ? words[widx] : W'($urandom);
            acc       = din_valid && em[3];
            @(posedge Clock);
            if (acc) widx++;
            if (pos < 0) pos = acc ? 0 : -1;
            else if (pos < total) pos++;
        end
        @(negedge Clock);
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        #1;
        checks++;
        if ({w_m, wv_m, last_m, w_l, wv_l, last_l} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold outputs got=%b exp=000000", {w_m, wv_m, last_m, w_l, wv_l, last_l});
        end
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            checks++;
            if ({rdy_m, w_m, wv_m, last_m, rdy_l, w_l, wv_l, last_l} !== 8'b1000_1000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=10001000", i,
                         {rdy_m, w_m, wv_m, last_m, rdy_l, w_l, wv_l, last_l});
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] q[$];
        q = {8'b0110_1100};
        run_stream("single_6c", q);
        q = {8'h01};
        run_stream("single_01", q);
        q = {8'h07};
        run_stream("single_07", q);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        q = {8'hFF, 8'h81};
        run_stream("b2b_ff_81", q);
        q = {8'h00, 8'hFF, 8'h00};
        run_stream("b2b_00_ff_00", q);
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        for (int t = 0; t < 12; t++) begin
            q = {};
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                q.push_back(W'($urandom));
            run_stream("random", q);
            repeat ($urandom_range(0, 3)) @(negedge Clock);
        end
    endtask

    task automatic test_midword_reset();
        @(negedge Clock);
        din       = 8'hF0;
        din_valid = 1'b1;
        @(posedge Clock);
        #1 din_valid = 1'b0;
        repeat (3) @(posedge Clock);
        #2;
        checks++;
        if ({w_m, wv_m, w_l, wv_l} !== 4'b1101) begin
            errors++;
            $display("FAIL midreset_bit4 {w_m,wv_m,w_l,wv_l} got=%b exp=1101", {w_m, wv_m, w_l, wv_l});
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({w_m, wv_m, last_m, w_l, wv_l, last_l} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async got=%b exp=000000", {w_m, wv_m, last_m, w_l, wv_l, last_l});
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            checks++;
            if ({rdy_m, w_m, wv_m, last_m, rdy_l, w_l, wv_l, last_l} !== 8'b1000_1000) begin
                errors++;
                $display("FAIL midreset_no_resend cyc=%0d got=%b exp=10001000", i,
                         {rdy_m, w_m, wv_m, last_m, rdy_l, w_l, wv_l, last_l});
            end
        end
        run_stream("after_reset", '{8'hA5});
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_midword_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
